// File: rtl/bram_input_pingpong.sv
// Double-buffered pixel store: the writer fills one bank in raster order while the reader streams the other.
// Latency: first rd_valid two clk edges after the edge that accepts rd_start; one beat per cycle after that.
// Backpressure: wr_ready drops while the target bank is full; rd_ready low freezes the output beat and stops BRAM reads.
// Optional feature: define BRAM_INPUT_PINGPONG_ZERO_PAD_EN to stream a one-pixel zero border around the bank.
module bram_input_pingpong #(
  parameter int DATA_WIDTH  = 8,
  parameter int IN_CHANNELS = 3,
  parameter int IN_WIDTH    = 5,
  parameter int IN_HEIGHT   = 5,
  parameter     RAM_STYLE   = "auto"
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_WIDTH*IN_CHANNELS-1:0] wr_data,
  input  logic                              wr_valid,
  output logic                              wr_ready,
  input  logic                              rd_start,
  output logic                              rd_busy,
  output logic [DATA_WIDTH*IN_CHANNELS-1:0] rd_data,
  output logic                              rd_valid,
  input  logic                              rd_ready,
  output logic                              rd_last,
  output logic [1:0]                        bank_full
);
  localparam int PW     = DATA_WIDTH * IN_CHANNELS;
  localparam int PIXELS = IN_WIDTH * IN_HEIGHT;
  localparam int AW     = (PIXELS > 1) ? $clog2(PIXELS) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(PIXELS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_DRAIN} rd_state_t;

  (* ram_style = RAM_STYLE *) logic [PW-1:0] bank0_mem [PIXELS];
  (* ram_style = RAM_STYLE *) logic [PW-1:0] bank1_mem [PIXELS];

  logic            wb_q, rb_q;
  logic [AW-1:0]   wr_cnt_q;
  logic [1:0]      bank_full_q, bank_full_d;
  rd_state_t       state_q;
  logic            rd_busy_q;
  logic [AW-1:0]   rd_addr_q;
  logic [PW-1:0]   b0_rd_q, b1_rd_q;
  logic            ram_vld_q, ram_last_q, ram_sel_q;
  logic            rd_valid_q, rd_last_q;
  logic [PW-1:0]   rd_data_q;
  logic [PW-1:0]   s1_dat;
  logic            wr_fire, wr_done, out_free, issue, iss_last, iss_rd_en, rd_release;

`ifdef BRAM_INPUT_PINGPONG_ZERO_PAD_EN
  localparam int PAD_W = IN_WIDTH + 2;
  localparam int PAD_H = IN_HEIGHT + 2;
  localparam int CW    = $clog2(PAD_W);
  localparam int RW    = $clog2(PAD_H);
  logic [CW-1:0] rd_col_q;
  logic [RW-1:0] rd_row_q;
  logic          ram_zero_q;
  logic          iss_interior;
  assign iss_interior = (rd_row_q != '0) && (rd_row_q != RW'(PAD_H - 1)) &&
                        (rd_col_q != '0) && (rd_col_q != CW'(PAD_W - 1));
  assign iss_last     = (rd_row_q == RW'(PAD_H - 1)) && (rd_col_q == CW'(PAD_W - 1));
  assign iss_rd_en    = issue && iss_interior;
  assign s1_dat       = ram_zero_q ? '0 : (ram_sel_q ? b1_rd_q : b0_rd_q);
`else
  assign iss_last  = (rd_addr_q == LAST_ADDR);
  assign iss_rd_en = issue;
  assign s1_dat    = ram_sel_q ? b1_rd_q : b0_rd_q;
`endif

  assign wr_ready   = !bank_full_q[wb_q];
  assign wr_fire    = wr_valid && wr_ready;
  assign wr_done    = wr_fire && (wr_cnt_q == LAST_ADDR);
  assign out_free   = !rd_valid_q || rd_ready;
  assign issue      = (state_q == ST_STREAM) && out_free;
  assign rd_release = (state_q == ST_DRAIN) && rd_valid_q && rd_ready && rd_last_q;

  // Pixel writes into the bank selected by the write pointer
  always_ff @(posedge clk) begin
    if (wr_fire && !wb_q) bank0_mem[wr_cnt_q] <= wr_data;
    if (wr_fire &&  wb_q) bank1_mem[wr_cnt_q] <= wr_data;
  end

  // Raster write counter and write-bank pointer; the pointer flips on the last pixel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt_q <= '0;
      wb_q     <= 1'b0;
    end else if (wr_done) begin
      wr_cnt_q <= '0;
      wb_q     <= ~wb_q;
    end else if (wr_fire) begin
      wr_cnt_q <= wr_cnt_q + AW'(1);
    end
  end

  // Completion and release can land on the same edge; they always target different banks
  always_comb begin
    bank_full_d = bank_full_q;
    if (rd_release) bank_full_d[rb_q] = 1'b0;
    if (wr_done)    bank_full_d[wb_q] = 1'b1;
  end

  // Bank full flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bank_full_q <= 2'b00;
    else     bank_full_q <= bank_full_d;
  end

  // Reader FSM: walks read addresses, then waits for the last beat to be taken before releasing the bank
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rd_busy_q <= 1'b0;
      rb_q      <= 1'b0;
      rd_addr_q <= '0;
`ifdef BRAM_INPUT_PINGPONG_ZERO_PAD_EN
      rd_col_q  <= '0;
      rd_row_q  <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rd_start && bank_full_q[rb_q]) begin
            state_q   <= ST_STREAM;
            rd_busy_q <= 1'b1;
            rd_addr_q <= '0;
`ifdef BRAM_INPUT_PINGPONG_ZERO_PAD_EN
            rd_col_q  <= '0;
            rd_row_q  <= '0;
`endif
          end
        end
        ST_STREAM: begin
          if (issue) begin
            if (iss_last) begin
              state_q <= ST_DRAIN;
            end else begin
`ifdef BRAM_INPUT_PINGPONG_ZERO_PAD_EN
              if (iss_interior) rd_addr_q <= rd_addr_q + AW'(1);
              if (rd_col_q == CW'(PAD_W - 1)) begin
                rd_col_q <= '0;
                rd_row_q <= rd_row_q + RW'(1);
              end else begin
                rd_col_q <= rd_col_q + CW'(1);
              end
`else
              rd_addr_q <= rd_addr_q + AW'(1);
`endif
            end
          end
        end
        ST_DRAIN: begin
          if (rd_release) begin
            state_q   <= ST_IDLE;
            rd_busy_q <= 1'b0;
            rb_q      <= ~rb_q;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          rd_busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Synchronous BRAM reads; both banks share the address and the captured bank select picks one
  always_ff @(posedge clk) begin
    if (iss_rd_en) begin
      b0_rd_q <= bank0_mem[rd_addr_q];
      b1_rd_q <= bank1_mem[rd_addr_q];
    end
  end

  // Read-stage tags; this stage only advances when the output stage is free, so it never overflows
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_vld_q  <= 1'b0;
      ram_last_q <= 1'b0;
      ram_sel_q  <= 1'b0;
`ifdef BRAM_INPUT_PINGPONG_ZERO_PAD_EN
      ram_zero_q <= 1'b0;
`endif
    end else if (out_free) begin
      ram_vld_q  <= issue;
      ram_last_q <= iss_last;
      ram_sel_q  <= rb_q;
`ifdef BRAM_INPUT_PINGPONG_ZERO_PAD_EN
      ram_zero_q <= !iss_interior;
`endif
    end
  end

  // Output register: loads from the read stage when empty or being consumed, holds otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
    end else if (out_free) begin
      rd_valid_q <= ram_vld_q;
      rd_last_q  <= ram_vld_q && ram_last_q;
      if (ram_vld_q) rd_data_q <= s1_dat;
    end
  end

  assign rd_busy   = rd_busy_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign rd_last   = rd_last_q;
  assign bank_full = bank_full_q;
endmodule

// File: tb/tb_bram_input_pingpong.sv
// Randomized bench for bram_input_pingpong with a bank/queue reference model sampled on the falling edge.
// Covers reset values, fills, streams under several rd_ready patterns, overlap, and mid-stream reset.
// Optional zero-pad build is covered by the same model when BRAM_INPUT_PINGPONG_ZERO_PAD_EN is defined.
module tb_bram_input_pingpong;
  localparam int DW  = 8;
  localparam int CH  = 3;
  localparam int W   = 5;
  localparam int H   = 5;
  localparam int PW  = DW * CH;
  localparam int PIX = W * H;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [PW-1:0] wr_data = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic          rd_start = 1'b0;
  logic          rd_busy;
  logic [PW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic          rd_last;
  logic [1:0]    bank_full;

  always #5 clk = ~clk;

  bram_input_pingpong #(
    .DATA_WIDTH(DW), .IN_CHANNELS(CH), .IN_WIDTH(W), .IN_HEIGHT(H), .RAM_STYLE("auto")
  ) dut (
    .clk(clk), .rst(rst),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_start(rd_start), .rd_busy(rd_busy),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
    .bank_full(bank_full)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: two pixel arrays, full flags, pointers, and a queue of beats still owed
  logic [PW-1:0] m_mem [2][PIX];
  logic [1:0]    m_full = 2'b00;
  int            m_wb = 0, m_rb = 0, m_wcnt = 0, m_done = 0;
  bit            m_idle = 1'b1;
  logic [PW-1:0] exp_q [$];
  bit            lat_armed = 1'b0;
  int            lat_edges = 0;
  bit            prev_stall = 1'b0;
  logic [PW-1:0] prev_dat;
  logic          prev_last;

  always @(negedge clk) begin
    bit wr_acc, start_acc;
    if (rst) begin
      m_full = 2'b00; m_wb = 0; m_rb = 0; m_wcnt = 0; m_idle = 1'b1;
      exp_q.delete(); lat_armed = 1'b0; prev_stall = 1'b0;
    end else begin
      // Outputs must reflect every edge seen so far
      chk("wr_ready", wr_ready, !m_full[m_wb]);
      chk("bank_full", bank_full, m_full);
      chk("rd_busy", rd_busy, !m_idle);
      if (m_idle) chk("idle_no_valid", rd_valid, 1'b0);
      if (prev_stall) begin
        chk("hold_valid", rd_valid, 1'b1);
        chk("hold_data", rd_data, prev_dat);
        chk("hold_last", rd_last, prev_last);
      end
      if (lat_armed) begin
        lat_edges++;
        if (rd_valid) begin
          chk("first_valid_latency", lat_edges, 2);
          lat_armed = 1'b0;
        end
      end
      // Predict the effect of the coming rising edge
      wr_acc    = wr_valid && !m_full[m_wb];
      start_acc = m_idle && rd_start && m_full[m_rb];
      if (start_acc) begin
`ifdef BRAM_INPUT_PINGPONG_ZERO_PAD_EN
        for (int r = 0; r < H + 2; r++)
          for (int c = 0; c < W + 2; c++)
            if (r >= 1 && r <= H && c >= 1 && c <= W) exp_q.push_back(m_mem[m_rb][(r-1)*W + (c-1)]);
            else exp_q.push_back('0);
`else
        for (int k = 0; k < PIX; k++) exp_q.push_back(m_mem[m_rb][k]);
`endif
        m_idle = 1'b0; lat_armed = 1'b1; lat_edges = -1;
      end
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) chk("beat_unexpected", 1, 0);
        else begin
          chk("beat_data", rd_data, exp_q[0]);
          chk("beat_last", rd_last, exp_q.size() == 1);
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) begin
            m_full[m_rb] = 1'b0; m_rb ^= 1; m_idle = 1'b1; m_done++;
          end
        end
      end
      if (wr_acc) begin
        m_mem[m_wb][m_wcnt] = wr_data;
        m_wcnt++;
        if (m_wcnt == PIX) begin
          m_wcnt = 0; m_full[m_wb] = 1'b1; m_wb ^= 1;
        end
      end
      prev_stall = rd_valid && !rd_ready;
      prev_dat   = rd_data;
      prev_last  = rd_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer PIX pixels (mode 0: k*0x010101, mode 1: random), holding each until accepted
  task automatic fill(input int mode);
    int k, guard;
    logic [PW-1:0] d;
    bit acc;
    k = 0; guard = 0;
    d = (mode == 0) ? PW'(0) : PW'($urandom);
    while (k < PIX && guard < 2000) begin
      wr_valid = 1'b1;
      wr_data  = d;
      acc = wr_ready;
      tick();
      guard++;
      if (acc) begin
        k++;
        d = (mode == 0) ? PW'(k * 'h010101) : PW'($urandom);
      end
    end
    wr_valid = 1'b0;
    chk("fill_done", k, PIX);
  endtask

  // Start a stream and consume it (rmode 0: ready high, 1: toggling, 2: random)
  task automatic stream(input int rmode);
    int target, guard;
    target = m_done + 1; guard = 0;
    rd_start = 1'b1;
    rd_ready = 1'b1;
    tick();
    rd_start = 1'b0;
    while (m_done < target && guard < 1000) begin
      case (rmode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = ~rd_ready;
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
      tick();
      guard++;
    end
    rd_ready = 1'b0;
    chk("stream_done", m_done >= target, 1'b1);
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_rd_last", rd_last, 1'b0);
    chk("rst_rd_data", rd_data, '0);
    chk("rst_rd_busy", rd_busy, 1'b0);
    chk("rst_bank_full", bank_full, 2'b00);
    chk("rst_wr_ready", wr_ready, 1'b1);
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // rd_start with nothing buffered is ignored
    rd_start = 1'b1; rd_ready = 1'b1;
    tick();
    rd_start = 1'b0;
    repeat (6) tick();
    chk("empty_start_valid", rd_valid, 1'b0);
    chk("empty_start_busy", rd_busy, 1'b0);

    // Pattern fill of bank 0, streamed with ready held high
    fill(0);
    chk("fill0_bank_full", bank_full, 2'b01);
    chk("fill0_wr_ready", wr_ready, 1'b1);
    stream(0);
    chk("bank0_released", bank_full[0], 1'b0);

    // Bank 1 random, ready toggling every cycle
    fill(1);
    stream(1);

    // Both banks full, then release bank 0 while a write is already waiting
    fill(1);
    fill(1);
    chk("both_full", bank_full, 2'b11);
    chk("both_full_wr_ready", wr_ready, 1'b0);
    fork
      fill(1);
      stream(2);
    join
    chk("refill_bank_full", bank_full, 2'b11);
    stream(0);
    stream(2);

    // Reset in the middle of a stream
    fill(1);
    rd_start = 1'b1; rd_ready = 1'b1;
    tick();
    rd_start = 1'b0;
    repeat (6) tick();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_rd_valid", rd_valid, 1'b0);
    chk("mid_rst_rd_last", rd_last, 1'b0);
    chk("mid_rst_rd_data", rd_data, '0);
    chk("mid_rst_rd_busy", rd_busy, 1'b0);
    chk("mid_rst_bank_full", bank_full, 2'b00);
    chk("mid_rst_wr_ready", wr_ready, 1'b1);
    repeat (2) tick();
    rst = 1'b0;
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    repeat (6) tick();
    chk("post_rst_no_valid", rd_valid, 1'b0);

    // Recovery after reset
    fill(1);
    stream(2);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end
endmodule
